c_shared_fifo_tracker: RTL



---
 rtl/c_shared_fifo_tracker_pkg.sv | 20 ++
 rtl/c_shared_fifo_tracker_if.sv | 32 +++
 rtl/c_shared_fifo_tracker_ctr.sv | 44 ++++
 rtl/c_shared_fifo_tracker.sv | 125 ++++++++++++
 4 files changed

// File: rtl/c_shared_fifo_tracker_pkg.sv
// Shared types and helpers for the shared-buffer FIFO occupancy tracker.
package c_shared_fifo_tracker_pkg;

   // Error flags as driven on the errors port: {underflow, overflow}.
   typedef struct packed {
      logic underflow;
      logic overflow;
   } err_t;

   // Per-queue effect on the shared pool for one clock.
   localparam logic signed [1:0] delta_take = -2'sd1;
   localparam logic signed [1:0] delta_none =  2'sd0;
   localparam logic signed [1:0] delta_give =  2'sd1;

   // Bits needed to index/count n values; never narrower than one bit.
   function automatic int clogb(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/c_shared_fifo_tracker_if.sv
// Push/pop request and status bundle between a buffer manager and the tracker.
interface c_shared_fifo_tracker_if
   import c_shared_fifo_tracker_pkg::*;
#(
   parameter int num_queues = 4,
   parameter int depth      = 16
);
   localparam int sel_width = clogb(num_queues);
   localparam int cnt_width = clogb(depth + 1);

   logic                            active;
   logic                            push;
   logic [sel_width-1:0]            push_sel;
   logic                            pop;
   logic [sel_width-1:0]            pop_sel;
   logic [num_queues*cnt_width-1:0] occ;
   logic [cnt_width-1:0]            shared_free;
   logic [num_queues-1:0]           empty;
   logic [num_queues-1:0]           almost_full;
   logic [num_queues-1:0]           full;
   logic [1:0]                      errors;

   modport master (
      output active, push, push_sel, pop, pop_sel,
      input  occ, shared_free, empty, almost_full, full, errors
   );

   modport slave (
      input  active, push, push_sel, pop, pop_sel,
      output occ, shared_free, empty, almost_full, full, errors
   );
endinterface

// File: rtl/c_shared_fifo_tracker_ctr.sv
// Occupancy counter for one logical queue; decides whether each push/pop
// lands in the queue's private reservation or in the shared pool.
module c_shared_fifo_tracker_ctr
   import c_shared_fifo_tracker_pkg::*;
#(
   parameter int cnt_width    = 5,
   parameter int min_reserved = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 active,
   input  logic                 inc,
   input  logic                 dec,
   output logic [cnt_width-1:0] occ,
   output logic [cnt_width-1:0] occ_nxt,
   output logic                 empty,
   output logic signed [1:0]    shared_delta
);
   localparam logic [cnt_width-1:0] min_res_c = cnt_width'(min_reserved);

   // Next occupancy and pool effect; push+pop on this queue cancels out.
   always_comb begin
      occ_nxt      = occ;
      shared_delta = delta_none;
      if (inc && !dec) begin
         occ_nxt = occ + 1'b1;
         if (occ >= min_res_c) shared_delta = delta_take;
      end else if (dec && !inc) begin
         occ_nxt = occ - 1'b1;
         if (occ > min_res_c) shared_delta = delta_give;
      end
   end

   // Occupancy and empty flag registers, frozen while inactive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ   <= '0;
         empty <= 1'b1;
      end else if (active) begin
         occ   <= occ_nxt;
         empty <= (occ_nxt == '0);
      end
   end
endmodule

// File: rtl/c_shared_fifo_tracker.sv
// Occupancy tracker for num_queues logical FIFOs sharing one buffer: each
// queue owns min_reserved private entries, the rest is a shared pool.
// Status flags are registered from next-state so they carry no glitches.
module c_shared_fifo_tracker
   import c_shared_fifo_tracker_pkg::*;
#(
   parameter int num_queues   = 4,
   parameter int depth        = 16,
   parameter int min_reserved = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   c_shared_fifo_tracker_if.slave  bus
);
   localparam int sel_width    = clogb(num_queues);
   localparam int cnt_width    = clogb(depth + 1);
   localparam int shared_depth = depth - num_queues * min_reserved;

   localparam logic [cnt_width-1:0] shared_depth_c = cnt_width'(shared_depth);
   localparam logic [cnt_width-1:0] min_res_c      = cnt_width'(min_reserved);
   localparam logic [cnt_width-1:0] one_c          = cnt_width'(1);
   localparam logic                 af_reset       = (min_reserved + shared_depth == 1);

   logic                    push_v, pop_v;
   logic                    push_in_range, pop_in_range;
   logic                    same_q, full_at_push, empty_at_pop;
   logic                    push_eff, pop_eff;
   err_t                    err;

   logic [cnt_width-1:0]    occ_q     [num_queues];
   logic [cnt_width-1:0]    occ_nxt_q [num_queues];
   logic                    empty_q   [num_queues];
   logic signed [1:0]       delta_q   [num_queues];

   logic [cnt_width-1:0]    shared_free_r, shared_free_nxt;
   logic [num_queues-1:0]   full_r, full_nxt;
   logic [num_queues-1:0]   af_r, af_nxt;
   logic [num_queues-1:0]   empty_w;

   // Legality of this cycle's push/pop against registered state only.
   always_comb begin
      push_v        = bus.active & bus.push;
      pop_v         = bus.active & bus.pop;
      push_in_range = ({1'b0, bus.push_sel} < (sel_width + 1)'(num_queues));
      pop_in_range  = ({1'b0, bus.pop_sel} < (sel_width + 1)'(num_queues));
      same_q        = push_v & pop_v & (bus.push_sel == bus.pop_sel);
      full_at_push  = push_in_range ? full_r[bus.push_sel] : 1'b0;
      empty_at_pop  = pop_in_range ? empty_w[bus.pop_sel] : 1'b0;
      err.overflow  = push_v & (~push_in_range | (full_at_push & ~same_q));
      err.underflow = pop_v & (~pop_in_range | (empty_at_pop & ~same_q));
      push_eff      = push_v & ~err.overflow;
      pop_eff       = pop_v & ~err.underflow;
   end

   for (genvar q = 0; q < num_queues; q++) begin : g_ctr
      c_shared_fifo_tracker_ctr #(
         .cnt_width    (cnt_width),
         .min_reserved (min_reserved)
      ) u_ctr (
         .clk          (clk),
         .reset        (reset),
         .active       (bus.active),
         .inc          (push_eff & (bus.push_sel == sel_width'(q))),
         .dec          (pop_eff & (bus.pop_sel == sel_width'(q))),
         .occ          (occ_q[q]),
         .occ_nxt      (occ_nxt_q[q]),
         .empty        (empty_q[q]),
         .shared_delta (delta_q[q])
      );
   end

   // Net pool change and next-state capacity flags for every queue.
   always_comb begin
      logic [cnt_width-1:0] give_cnt;
      logic [cnt_width-1:0] take_cnt;
      logic [cnt_width-1:0] res_left;
      logic [cnt_width-1:0] cap;
      give_cnt = '0;
      take_cnt = '0;
      res_left = '0;
      cap      = '0;
      full_nxt = '0;
      af_nxt   = '0;
      for (int q = 0; q < num_queues; q++) begin
         if (delta_q[q] == delta_give) give_cnt = give_cnt + 1'b1;
         if (delta_q[q] == delta_take) take_cnt = take_cnt + 1'b1;
      end
      shared_free_nxt = shared_free_r + give_cnt - take_cnt;
      for (int q = 0; q < num_queues; q++) begin
         res_left    = (occ_nxt_q[q] < min_res_c) ? (min_res_c - occ_nxt_q[q]) : '0;
         cap         = res_left + shared_free_nxt;
         full_nxt[q] = (cap == '0);
         af_nxt[q]   = (cap == one_c);
      end
   end

   // Pool and flag registers, frozen while inactive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shared_free_r <= shared_depth_c;
         full_r        <= '0;
         af_r          <= {num_queues{af_reset}};
      end else if (bus.active) begin
         shared_free_r <= shared_free_nxt;
         full_r        <= full_nxt;
         af_r          <= af_nxt;
      end
   end

   // Pack per-queue state onto the bus; queue 0 occupies the MSBs of occ.
   always_comb begin
      bus.occ = '0;
      empty_w = '0;
      for (int q = 0; q < num_queues; q++) begin
         bus.occ[(num_queues - 1 - q) * cnt_width +: cnt_width] = occ_q[q];
         empty_w[q] = empty_q[q];
      end
   end

   assign bus.empty       = empty_w;
   assign bus.full        = full_r;
   assign bus.almost_full = af_r;
   assign bus.shared_free = shared_free_r;
   assign bus.errors      = err;
endmodule
